// File: rtl/mdio_frame_master.sv
// Clause-22 MDIO frame master: sends preamble plus one 32-bit command word on
// MDC/MDIO, captures read data and reports level done flags per frame type.
module mdio_frame_master #(
  parameter int unsigned DIV          = 25,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_done,
  output logic        wr_done,
  output logic        rd_err,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe
);

  localparam int unsigned DIV_W = $clog2(2 * DIV);
  localparam int unsigned CNT_W = 5;
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(2 * DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(13);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sh_q, sh_d;
  logic [14:0]      rsh_q, rsh_d;
  logic             is_rd_q, is_rd_d;
  logic             ta_err_q, ta_err_d;
  logic [1:0]       sync_q, sync_d;
  logic             busy_q, busy_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_done_q, rd_done_d;
  logic             wr_done_q, wr_done_d;
  logic             rd_err_q, rd_err_d;
  logic             mdc_q, mdc_d;
  logic             mdio_o_q, mdio_o_d;
  logic             mdio_oe_q, mdio_oe_d;
  logic             mdio_s;

  assign mdio_s = sync_q[1];

  // Next-state, bit sequencing and registered pad values for the upcoming bit
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rsh_d     = rsh_q;
    is_rd_d   = is_rd_q;
    ta_err_d  = ta_err_q;
    sync_d    = {sync_q[0], mdio_i};
    busy_d    = busy_q;
    rd_data_d = rd_data_q;
    rd_done_d = rd_done_q;
    wr_done_d = wr_done_q;
    rd_err_d  = rd_err_q;
    mdc_d     = mdc_q;
    mdio_o_d  = 1'b1;
    mdio_oe_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = wr_data;
          is_rd_d = wr_data[29];
          div_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          mdc_d   = 1'b0;
          state_d = (PREAMBLE_LEN == 0) ? S_HDR : S_PRE;
          if (wr_data[29]) rd_done_d = 1'b0;
          else             wr_done_d = 1'b0;
        end
      end
      S_PRE, S_HDR, S_TA, S_DATA: begin
        div_d = div_q + DIV_W'(1);
        if (div_q == HALF_LAST) mdc_d = 1'b1;
        if (div_q == BIT_LAST) begin
          div_d = '0;
          mdc_d = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
          case (state_q)
            S_PRE: begin
              if (cnt_q == PRE_LAST) begin
                state_d = S_HDR;
                cnt_d   = '0;
              end
            end
            S_HDR: begin
              sh_d = {sh_q[30:0], 1'b0};
              if (cnt_q == HDR_LAST) begin
                state_d = S_TA;
                cnt_d   = '0;
              end
            end
            S_TA: begin
              sh_d = {sh_q[30:0], 1'b0};
              if (cnt_q[0]) begin
                ta_err_d = mdio_s;
                state_d  = S_DATA;
                cnt_d    = '0;
              end
            end
            default: begin
              sh_d  = {sh_q[30:0], 1'b0};
              rsh_d = {rsh_q[13:0], mdio_s};
              if (cnt_q == DATA_LAST) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                if (is_rd_q) begin
                  rd_done_d = 1'b1;
                  rd_data_d = {rsh_q, mdio_s};
                  rd_err_d  = ta_err_q;
                end else begin
                  wr_done_d = 1'b1;
                end
              end
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pad values follow the bit being entered; read frames release the bus from TA on
    case (state_d)
      S_PRE: begin
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b1;
      end
      S_HDR: begin
        mdio_o_d  = sh_d[31];
        mdio_oe_d = 1'b1;
      end
      S_TA, S_DATA: begin
        mdio_o_d  = sh_d[31];
        mdio_oe_d = ~is_rd_d;
      end
      default: begin
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      rsh_q     <= '0;
      is_rd_q   <= 1'b0;
      ta_err_q  <= 1'b0;
      sync_q    <= 2'b11;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
      rd_done_q <= 1'b1;
      wr_done_q <= 1'b1;
      rd_err_q  <= 1'b0;
      mdc_q     <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rsh_q     <= rsh_d;
      is_rd_q   <= is_rd_d;
      ta_err_q  <= ta_err_d;
      sync_q    <= sync_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      rd_err_q  <= rd_err_d;
      mdc_q     <= mdc_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
    end
  end

  assign busy    = busy_q;
  assign rd_data = rd_data_q;
  assign rd_done = rd_done_q;
  assign wr_done = wr_done_q;
  assign rd_err  = rd_err_q;
  assign mdc     = mdc_q;
  assign mdio_o  = mdio_o_q;
  assign mdio_oe = mdio_oe_q;

endmodule

// File: tb/tb_mdio_frame_master.sv
// Bench for mdio_frame_master: a PHY model on the wire, a reference model of
// expected completions, and a monitor that scores each done-flag rise.
module tb_mdio_frame_master;

  localparam int unsigned DIV       = 4;
  localparam int unsigned PRE       = 32;
  localparam int unsigned FRAME_CYC = 2 * DIV * (PRE + 32);

  typedef struct {
    logic        is_rd;
    logic [31:0] cmd;
    logic [15:0] rdata;
    logic        rerr;
    longint      done_cyc;
  } exp_t;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] wr_data = '0;
  logic        mdio_i = 1'b1;
  logic        busy, rd_done, wr_done, rd_err, mdc, mdio_o, mdio_oe;
  logic [15:0] rd_data;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  exp_t exp_q[$];
  frm_t frm_q[$];

  logic [15:0] phy_regs[32];
  logic [15:0] mdl_regs[32];
  logic        phy_ta_bad = 1'b0;
  logic [15:0] mdl_rd_data = '0;
  logic        mdl_rd_err = 1'b0;
  logic        skip_len = 1'b0;

  mdio_frame_master #(.DIV(DIV), .PREAMBLE_LEN(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_data(wr_data),
    .busy(busy), .rd_data(rd_data), .rd_done(rd_done), .wr_done(wr_done),
    .rd_err(rd_err), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe(mdio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // PHY model: samples on MDC rise, answers reads, applies writes to its register file
  int          idx = 0;
  logic        mdc_prev = 1'b0;
  logic        o_prev = 1'b1;
  logic        oe_prev = 1'b0;
  int          hi_run = 0;
  logic [63:0] fr = '0;
  logic [63:0] oem = '0;
  logic [15:0] rdv = '0;

  always @(negedge clk) begin
    if (mdc && !mdc_prev && busy) begin
      if (idx >= 64) begin
        checks++;
        errors++;
        $display("FAIL mdc_edges actual=%0d required<=64", idx + 1);
      end else begin
        fr[63-idx]  = mdio_o;
        oem[63-idx] = mdio_oe;
        if (fr[29]) begin
          if (idx == 46) rdv = phy_ta_bad ? 16'hFFFF : phy_regs[fr[22:18]];
          else if (idx == 47) mdio_i = phy_ta_bad;
          else if (idx >= 48) mdio_i = rdv[63-idx];
        end
        if (idx == 63) begin
          frm_q.push_back('{fr, oem});
          if (fr[29:28] == 2'b01) phy_regs[fr[22:18]] = fr[15:0];
        end
        idx++;
      end
    end
    if (mdio_o !== o_prev || mdio_oe !== oe_prev) chk("mdio_change_mdc_low", 64'(mdc), 64'd0);
    if (skip_len) hi_run = 0;
    else if (mdc) hi_run++;
    else begin
      if (mdc_prev) chk("mdc_high_len", 64'(hi_run), 64'(DIV));
      hi_run = 0;
    end
    if (!busy) begin
      idx    = 0;
      mdio_i = 1'b1;
    end
    mdc_prev = mdc;
    o_prev   = mdio_o;
    oe_prev  = mdio_oe;
  end

  // Monitor: each done-flag rise retires one expected completion and one wire frame
  logic prev_rd = 1'b1;
  logic prev_wr = 1'b1;
  logic rd_rise, wr_rise;
  exp_t me;
  frm_t mf;
  logic [63:0] mask;

  always @(negedge clk) begin
    if (rst_n) begin
      rd_rise = rd_done && !prev_rd;
      wr_rise = wr_done && !prev_wr;
      if (rd_rise || wr_rise) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=rd%0d/wr%0d required=none", rd_rise, wr_rise);
        end else begin
          me = exp_q.pop_front();
          chk("done_kind", 64'(rd_rise), 64'(me.is_rd));
          chk("done_cycle", 64'(cyc), 64'(me.done_cyc));
          chk("rd_data", 64'(rd_data), 64'(me.rdata));
          chk("rd_err", 64'(rd_err), 64'(me.rerr));
          chk("busy_at_done", 64'(busy), 64'd0);
          chk("other_done", 64'(me.is_rd ? wr_done : rd_done), 64'd1);
          mask = me.is_rd ? 64'hFFFF_FFFF_FFFC_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
          if (frm_q.size() == 0) chk("frame_present", 64'd0, 64'd1);
          else begin
            mf = frm_q.pop_front();
            chk("frame_bits", mf.bits & mask, {32'hFFFF_FFFF, me.cmd} & mask);
            chk("frame_oe", mf.oe, mask);
          end
        end
      end
    end
    prev_rd = rd_done;
    prev_wr = wr_done;
  end

  // Caller must be just past a negedge with the DUT idle
  task automatic issue(input logic [31:0] cmd);
    exp_t e;
    start   = 1'b1;
    wr_data = cmd;
    @(posedge clk);
    #1;
    e.is_rd    = cmd[29];
    e.cmd      = cmd;
    e.done_cyc = cyc + longint'(FRAME_CYC);
    if (cmd[29]) begin
      mdl_rd_data = phy_ta_bad ? 16'hFFFF : mdl_regs[cmd[22:18]];
      mdl_rd_err  = phy_ta_bad;
    end else if (cmd[28]) begin
      mdl_regs[cmd[22:18]] = cmd[15:0];
    end
    e.rdata = mdl_rd_data;
    e.rerr  = mdl_rd_err;
    exp_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    wr_data = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (2 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_rd_done"}, 64'(rd_done), 64'd1);
    chk({tag, "_wr_done"}, 64'(wr_done), 64'd1);
    chk({tag, "_rd_err"}, 64'(rd_err), 64'd0);
    chk({tag, "_mdc"}, 64'(mdc), 64'd0);
    chk({tag, "_mdio_o"}, 64'(mdio_o), 64'd1);
    chk({tag, "_mdio_oe"}, 64'(mdio_oe), 64'd0);
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] pa,
                                     input logic [4:0] ra, input logic [1:0] ta,
                                     input logic [15:0] d);
    return {2'b01, op, pa, ra, ta, d};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] cmd;
    for (int i = 0; i < 32; i++) begin
      phy_regs[i] = 16'($urandom);
      mdl_regs[i] = phy_regs[i];
    end
    phy_regs[17] = 16'h2C00;
    mdl_regs[17] = 16'h2C00;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write frame; read flag must stay high throughout
    issue(mk(2'b01, 5'd1, 5'd4, 2'b10, 16'h1234));
    repeat (10) @(negedge clk);
    chk("write_rd_done_high", 64'(rd_done), 64'd1);
    chk("write_wr_done_low", 64'(wr_done), 64'd0);
    wait_done(FRAME_CYC + 50);

    // Read of register 17
    issue(mk(2'b10, 5'd1, 5'd17, 2'b00, 16'h0));
    wait_done(FRAME_CYC + 50);

    // Turnaround error with all-ones data
    phy_ta_bad = 1'b1;
    issue(mk(2'b10, 5'd1, 5'd5, 2'b00, 16'h0));
    wait_done(FRAME_CYC + 50);
    phy_ta_bad = 1'b0;

    // Second start while busy is dropped
    issue(mk(2'b01, 5'd2, 5'd9, 2'b10, 16'hBEEF));
    repeat (98) @(negedge clk);
    start   = 1'b1;
    wr_data = mk(2'b01, 5'd7, 5'd3, 2'b10, 16'h5555);
    @(negedge clk);
    start = 1'b0;
    wait_done(FRAME_CYC + 50);
    repeat (20) @(negedge clk);
    chk("ignored_start_busy", 64'(busy), 64'd0);
    chk("ignored_start_wr_done", 64'(wr_done), 64'd1);

    // Reset in the middle of a read, then a clean read
    issue(mk(2'b10, 5'd1, 5'd17, 2'b00, 16'h0));
    repeat (199) @(negedge clk);
    skip_len = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_vals("abort");
    exp_q.delete();
    frm_q.delete();
    mdl_rd_data = '0;
    mdl_rd_err  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    skip_len = 1'b0;
    repeat (2) @(negedge clk);
    issue(mk(2'b10, 5'd1, 5'd4, 2'b00, 16'h0));
    wait_done(FRAME_CYC + 50);

    // Back-to-back reads: restart in the cycle after the done cycle
    issue(mk(2'b10, 5'd3, 5'd17, 2'b00, 16'h0));
    for (int n = 0; n < FRAME_CYC + 50 && !rd_done; n++) @(negedge clk);
    chk("b2b_first_done", 64'(rd_done), 64'd1);
    @(negedge clk);
    issue(mk(2'b11, 5'd3, 5'd9, 2'b00, 16'h0));
    chk("b2b_rd_done_low", 64'(rd_done), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(2 * FRAME_CYC + 50);

    // Randomised mix of reads and writes
    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 2))
        0:       op = 2'b01;
        1:       op = 2'b10;
        default: op = 2'b11;
      endcase
      cmd = mk(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
               2'b10, 16'($urandom));
      issue(cmd);
      wait_done(FRAME_CYC + 50);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
